prio_enc_rr: RTL



---
 rtl/prio_enc_rr_pkg.sv | 8 +
 rtl/prio_pick.sv | 25 ++
 rtl/prio_enc_rr.sv | 44 ++++
 3 files changed

// File: rtl/prio_enc_rr_pkg.sv
// prio_enc_rr_pkg: shared index-width helper and mode encodings for prio_enc_rr
package prio_enc_rr_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int idx_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational rotate/find-highest/un-rotate picker; req,ptr,mode in -> idx,found out
module prio_pick
  import prio_enc_rr_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [W-1:0] s;
  logic [W-1:0] j;
  logic [W:0] sum;
  assign s = mode == MODE_RR ? ptr : '0;
  always_comb begin
    j = '0;
    for (int k = 0; k < N; k++) if (req[(k + int'(s)) % N]) j = W'(k);
  end
  assign sum = {1'b0, j} + {1'b0, s};
  assign idx = sum >= (W+1)'(N) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  assign found = |req;
endmodule

// File: rtl/prio_enc_rr.sv
// prio_enc_rr: queued fixed/round-robin priority encoder; clk,rst,en,d,mode,rdy in -> a,v,busy out
module prio_enc_rr
  import prio_enc_rr_pkg::*;
#(
  parameter int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] d,
  input  logic         mode,
  input  logic         rdy,
  output logic [W-1:0] a,
  output logic         v,
  output logic         busy
);
  logic [N-1:0] p, nxt;
  logic [W-1:0] ptr, w;
  logic load, found;
  assign nxt = p | (en ? d : '0);
  assign load = !v || rdy;
  assign busy = (|p) || v;
  prio_pick #(.N(N)) u_pick (.req(nxt), .ptr(ptr), .mode(mode), .idx(w), .found(found));
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      v <= 1'b0;
      p <= '0;
      ptr <= '0;
    end else if (load && found) begin
      a <= w;
      v <= 1'b1;
      p <= nxt & ~(N'(1) << w);
      ptr <= w;
    end else if (load) begin
      a <= '0;
      v <= 1'b0;
      p <= '0;
    end else begin
      p <= nxt;
    end
  end
endmodule
